puzzle_move_unit: RTL

PUZZLE_MOVE_UNIT -- requirements
Module: puzzle_move_unit

---
 rtl/puzzle_pkg.sv | 44 ++++
 rtl/blank_locator.sv | 25 ++
 rtl/puzzle_move_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/puzzle_pkg.sv
// Shared constants, state/direction encodings and board helpers for the
// 2x3 sliding-puzzle move unit.
package puzzle_pkg;

   localparam int CELL_W  = 3;
   localparam int N_CELLS = 6;
   localparam int N_COLS  = 3;
   localparam int BOARD_W = CELL_W * N_CELLS;

   localparam logic [3:0]         REG_ORD      = 4'd0;
   localparam logic [3:0]         REG_CNT      = 4'd1;
   localparam logic [BOARD_W-1:0] SOLVED_BOARD = 18'o123450;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CALC   = 3'd1,
      ST_WR_ORD = 3'd2,
      ST_WR_CNT = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   // Cell 0 sits in the most significant 3-bit slot of the board word.
   function automatic logic [BOARD_W-1:0] swap_cells(input logic [BOARD_W-1:0] b,
                                                     input logic [2:0] pa,
                                                     input logic [2:0] pb);
      logic [BOARD_W-1:0] r;
      logic [CELL_W-1:0]  ca;
      logic [CELL_W-1:0]  cb;
      r  = b;
      ca = b[(N_CELLS-1-int'(pa))*CELL_W +: CELL_W];
      cb = b[(N_CELLS-1-int'(pb))*CELL_W +: CELL_W];
      r[(N_CELLS-1-int'(pa))*CELL_W +: CELL_W] = cb;
      r[(N_CELLS-1-int'(pb))*CELL_W +: CELL_W] = ca;
      return r;
   endfunction

endpackage

// File: rtl/blank_locator.sv
// Finds the blank (zero) cell of a board; valid only when exactly one
// blank is present.
module blank_locator
   import puzzle_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   output logic [2:0]         pos,
   output logic               valid
);

   logic [2:0] n_blank;

   always_comb begin
      pos     = 3'd0;
      n_blank = 3'd0;
      for (int i = N_CELLS-1; i >= 0; i--) begin
         if (board[(N_CELLS-1-i)*CELL_W +: CELL_W] == '0) begin
            pos     = 3'(i);
            n_blank = n_blank + 3'd1;
         end
      end
      valid = (n_blank == 3'd1);
   end

endmodule

// File: rtl/puzzle_move_unit.sv
// Applies one blank-move command to the board snapshot and writes the new
// board and incremented move count back to the register file.
module puzzle_move_unit
   import puzzle_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_dir,
   input  logic [39:0] ord,
   input  logic [39:0] cnt,
   output logic        we,
   output logic [3:0]  dst,
   output logic [39:0] data,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic        solved
);

   // Handshake: a command is taken on any rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready is high only in IDLE.

   state_t             state_q, state_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [39:0]        cnt_q, cnt_d;
   dir_t               dir_q, dir_d;
   logic               we_q, we_d;
   logic [3:0]         dst_q, dst_d;
   logic [39:0]        data_q, data_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic               solved_q, solved_d;

   logic [2:0]         blank_pos;
   logic               blank_ok;
   logic               legal;
   logic [2:0]         tgt_pos;
   logic [BOARD_W-1:0] new_board;

   blank_locator u_blank_locator (
      .board (board_q),
      .pos   (blank_pos),
      .valid (blank_ok)
   );

   always_comb begin
      legal   = 1'b0;
      tgt_pos = blank_pos;
      case (dir_q)
         DIR_UP:    if (blank_pos >= 3'd3) begin legal = 1'b1; tgt_pos = blank_pos - 3'd3; end
         DIR_DOWN:  if (blank_pos <= 3'd2) begin legal = 1'b1; tgt_pos = blank_pos + 3'd3; end
         DIR_LEFT:  if (blank_pos != 3'd0 && blank_pos != 3'd3) begin legal = 1'b1; tgt_pos = blank_pos - 3'd1; end
         DIR_RIGHT: if (blank_pos != 3'd2 && blank_pos != 3'd5) begin legal = 1'b1; tgt_pos = blank_pos + 3'd1; end
         default:   legal = 1'b0;
      endcase
      legal     = legal & blank_ok;
      new_board = swap_cells(board_q, blank_pos, tgt_pos);
   end

   // Outputs are registered from the next state, so they are valid for
   // exactly the cycle the FSM spends in the corresponding state.
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      we_d        = 1'b0;
      dst_d       = 4'd0;
      data_d      = 40'd0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      solved_d    = solved_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               board_d  = ord[BOARD_W-1:0];
               cnt_d    = cnt;
               dir_d    = dir_t'(cmd_dir);
               solved_d = (ord[BOARD_W-1:0] == SOLVED_BOARD);
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            if (legal) begin
               board_d = new_board;
               we_d    = 1'b1;
               dst_d   = REG_ORD;
               data_d  = {22'd0, new_board};
               state_d = ST_WR_ORD;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_WR_ORD: begin
            solved_d = (board_q == SOLVED_BOARD);
            we_d     = 1'b1;
            dst_d    = REG_CNT;
            data_d   = cnt_q + 40'd1;
            state_d  = ST_WR_CNT;
         end
         ST_WR_CNT: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         board_q     <= '0;
         cnt_q       <= '0;
         dir_q       <= DIR_UP;
         we_q        <= 1'b0;
         dst_q       <= 4'd0;
         data_q      <= 40'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         solved_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         we_q        <= we_d;
         dst_q       <= dst_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         solved_q    <= solved_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign we        = we_q;
   assign dst       = dst_q;
   assign data      = data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign solved    = solved_q;

endmodule
